// File: rtl/writeback_unit_if.sv
// Result handshake between the execute stage (master) and the writeback unit (slave).
// One result plus optional NZCV update is transferred when valid and ready are both high.
interface writeback_unit_if;
    logic        resValidIn;
    logic        resReadyOut;
    logic [31:0] resDataIn;
    logic [3:0]  resAddrIn;
    logic        resWeIn;
    logic [3:0]  flagsIn;
    logic        flagsWeIn;

    modport master (
        output resValidIn, resDataIn, resAddrIn, resWeIn, flagsIn, flagsWeIn,
        input  resReadyOut
    );

    modport slave (
        input  resValidIn, resDataIn, resAddrIn, resWeIn, flagsIn, flagsWeIn,
        output resReadyOut
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: queues execute results and commits them to the register bank with a
// toggle strobe (IDLE -> SETUP -> FIRE), updates CPSR flags and redirects on r15 writes.
module writeback_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_unit_if.slave    res,
    output logic               triggerOutw,
    output logic [31:0]        dataOut,
    output logic [3:0]         addrOut,
    output logic [31:0]        cpsrOut,
    output logic               branchOut,
    output logic [31:0]        pcOut,
    output logic [15:0]        writeCount
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  addr;
        logic        we;
        logic [3:0]  flags;
        logic        fwe;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SETUP, FIRE} state_t;

    entry_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    state_t          r_state;
    logic            r_trig, r_branch;
    logic [31:0]     r_data, r_pc;
    logic [3:0]      r_addr, r_flags;
    logic [15:0]     r_wcnt;

    logic   w_ready, w_push, w_pop, w_nempty;
    entry_t w_head, w_in;

    // Ready comes from registered occupancy only, so a full FIFO never accepts on a pop cycle.
    assign w_ready  = (r_count != CW'(FIFO_DEPTH));
    assign w_push   = res.resValidIn & w_ready & (res.resWeIn | res.flagsWeIn);
    assign w_pop    = (r_state == SETUP);
    assign w_nempty = (r_count != '0);
    assign w_head   = r_mem[r_rptr];
    assign w_in     = '{data: res.resDataIn, addr: res.resAddrIn, we: res.resWeIn,
                        flags: res.flagsIn, fwe: res.flagsWeIn};

    assign res.resReadyOut = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_in;
                r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_trig   <= 1'b0;
            r_data   <= '0;
            r_addr   <= '0;
            r_flags  <= '0;
            r_branch <= 1'b0;
            r_pc     <= '0;
            r_wcnt   <= '0;
        end else begin
            r_branch <= 1'b0;
            case (r_state)
                IDLE, FIRE: begin
                    if (w_nempty) begin
                        r_state <= SETUP;
                        // Bus holds through flag-only entries so the bank never sees a spurious value.
                        if (w_head.we) begin
                            r_data <= w_head.data;
                            r_addr <= w_head.addr;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETUP: begin
                    r_state <= FIRE;
                    if (w_head.we) begin
                        r_trig <= ~r_trig;
                        r_wcnt <= r_wcnt + 16'd1;
                        if (w_head.addr == 4'd15) begin
                            r_branch <= 1'b1;
                            r_pc     <= w_head.data;
                        end
                    end
                    if (w_head.fwe)
                        r_flags <= w_head.flags;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign triggerOutw = r_trig;
    assign dataOut     = r_data;
    assign addrOut     = r_addr;
    assign cpsrOut     = {r_flags, 28'd0};
    assign branchOut   = r_branch;
    assign pcOut       = r_pc;
    assign writeCount  = r_wcnt;
endmodule
